// File: rtl/mtrap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: cause codes,
// FSM state encoding and next-PC select encodings.
package mtrap_ctrl_pkg;

  // Interrupt cause codes
  localparam int CAUSE_IRQ_EXT = 11;
  localparam int CAUSE_IRQ_SW  = 3;
  localparam int CAUSE_IRQ_TMR = 7;

  // Exception cause codes
  localparam int CAUSE_INSTR_MISALIGN = 0;
  localparam int CAUSE_ILLEGAL        = 2;
  localparam int CAUSE_EBREAK         = 3;
  localparam int CAUSE_ECALL          = 11;
  localparam int CAUSE_LOAD_MISALIGN  = 4;
  localparam int CAUSE_STORE_MISALIGN = 6;

  typedef enum logic [1:0] {
    ST_OPERATING   = 2'b00,
    ST_TRAP_TAKEN  = 2'b01,
    ST_TRAP_RETURN = 2'b10
  } state_t;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_TRAP = 2'b01;
  localparam logic [1:0] PC_SEL_MEPC = 2'b10;

endpackage

// File: rtl/mtrap_prio_enc.sv
// Combinational trap priority encoder. Enabled interrupts (gated by
// mstatus.MIE) outrank every exception; within each group the fixed
// priority order below applies.
module mtrap_prio_enc
  import mtrap_ctrl_pkg::*;
#(
  parameter int CAUSE_W = 4
) (
  input  logic               i_instr_misaligned,
  input  logic               i_illegal_instr,
  input  logic               i_ebreak,
  input  logic               i_ecall,
  input  logic               i_load_misaligned,
  input  logic               i_store_misaligned,
  input  logic               i_e_irq,
  input  logic               i_t_irq,
  input  logic               i_s_irq,
  input  logic               i_mie,
  input  logic               i_meie,
  input  logic               i_mtie,
  input  logic               i_msie,
  output logic               o_valid,
  output logic [CAUSE_W-1:0] o_cause,
  output logic               o_irq
);

  logic w_ext, w_sw, w_tmr;

  assign w_ext = i_mie & i_e_irq & i_meie;
  assign w_sw  = i_mie & i_s_irq & i_msie;
  assign w_tmr = i_mie & i_t_irq & i_mtie;

  // Pick the highest-priority pending event: external > software > timer,
  // then exceptions in architectural order.
  always_comb begin
    o_valid = 1'b1;
    o_irq   = 1'b1;
    o_cause = '0;
    if (w_ext)                   o_cause = CAUSE_W'(CAUSE_IRQ_EXT);
    else if (w_sw)               o_cause = CAUSE_W'(CAUSE_IRQ_SW);
    else if (w_tmr)              o_cause = CAUSE_W'(CAUSE_IRQ_TMR);
    else begin
      o_irq = 1'b0;
      if (i_instr_misaligned)      o_cause = CAUSE_W'(CAUSE_INSTR_MISALIGN);
      else if (i_illegal_instr)    o_cause = CAUSE_W'(CAUSE_ILLEGAL);
      else if (i_ebreak)           o_cause = CAUSE_W'(CAUSE_EBREAK);
      else if (i_ecall)            o_cause = CAUSE_W'(CAUSE_ECALL);
      else if (i_load_misaligned)  o_cause = CAUSE_W'(CAUSE_LOAD_MISALIGN);
      else if (i_store_misaligned) o_cause = CAUSE_W'(CAUSE_STORE_MISALIGN);
      else                         o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/mtrap_ctrl.sv
// Machine-mode trap controller. Detects traps / MRET while operating,
// spends one cycle in TRAP_TAKEN or TRAP_RETURN driving the CSR and
// PC-redirect strobes, and holds the last trap's cause and target.
// All outputs come straight from flops.
// Build option: MTRAP_CTRL_VECTORED_EN enables vectored interrupt targets
// (mtvec mode 01 -> base + 4*cause); otherwise the direct base is used.
module mtrap_ctrl
  import mtrap_ctrl_pkg::*;
#(
  parameter int CAUSE_W = 4,
  parameter int XLEN    = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               instr_misaligned_in,
  input  logic               illegal_instr_in,
  input  logic               ebreak_in,
  input  logic               ecall_in,
  input  logic               load_misaligned_in,
  input  logic               store_misaligned_in,
  input  logic               e_irq_in,
  input  logic               t_irq_in,
  input  logic               s_irq_in,
  input  logic               mie_in,
  input  logic               meie_in,
  input  logic               mtie_in,
  input  logic               msie_in,
  input  logic               mret_in,
  input  logic [XLEN-1:0]    mtvec_in,
  output logic               set_cause_out,
  output logic [CAUSE_W-1:0] cause_out,
  output logic               i_or_e_out,
  output logic               set_epc_out,
  output logic               mie_clear_out,
  output logic               mie_set_out,
  output logic               flush_out,
  output logic [1:0]         pc_sel_out,
  output logic [XLEN-1:0]    trap_addr_out
);

  state_t r_state, w_nxt_state;

  logic               w_trap_vld, w_trap_irq;
  logic [CAUSE_W-1:0] w_trap_cause;
  logic [XLEN-1:0]    w_base, w_trap_addr;

  logic [CAUSE_W-1:0] w_nxt_cause;
  logic               w_nxt_irq;
  logic [XLEN-1:0]    w_nxt_addr;

  logic               r_set_cause, r_set_epc, r_mie_clear, r_mie_set, r_flush;
  logic [1:0]         r_pc_sel;
  logic [CAUSE_W-1:0] r_cause;
  logic               r_irq;
  logic [XLEN-1:0]    r_addr;

  mtrap_prio_enc #(.CAUSE_W(CAUSE_W)) u_prio (
    .i_instr_misaligned (instr_misaligned_in),
    .i_illegal_instr    (illegal_instr_in),
    .i_ebreak           (ebreak_in),
    .i_ecall            (ecall_in),
    .i_load_misaligned  (load_misaligned_in),
    .i_store_misaligned (store_misaligned_in),
    .i_e_irq            (e_irq_in),
    .i_t_irq            (t_irq_in),
    .i_s_irq            (s_irq_in),
    .i_mie              (mie_in),
    .i_meie             (meie_in),
    .i_mtie             (mtie_in),
    .i_msie             (msie_in),
    .o_valid            (w_trap_vld),
    .o_cause            (w_trap_cause),
    .o_irq              (w_trap_irq)
  );

  // Mode bits are masked off to form the 4-byte aligned base.
  assign w_base = mtvec_in & ~XLEN'(2'b11);

`ifdef MTRAP_CTRL_VECTORED_EN
  logic [XLEN-1:0] w_vec_off;
  assign w_vec_off   = XLEN'(w_trap_cause) << 2;
  assign w_trap_addr = (w_trap_irq && (mtvec_in[1:0] == 2'b01)) ? (w_base + w_vec_off) : w_base;
`else
  assign w_trap_addr = w_base;
`endif

  // State register; reset aborts any in-flight trap/return state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= ST_OPERATING;
    else        r_state <= w_nxt_state;
  end

  // Next state plus the trap record to capture; a trap beats MRET, and
  // events are ignored outside OPERATING.
  always_comb begin
    w_nxt_state = ST_OPERATING;
    w_nxt_cause = r_cause;
    w_nxt_irq   = r_irq;
    w_nxt_addr  = r_addr;
    case (r_state)
      ST_OPERATING: begin
        if (w_trap_vld) begin
          w_nxt_state = ST_TRAP_TAKEN;
          w_nxt_cause = w_trap_cause;
          w_nxt_irq   = w_trap_irq;
          w_nxt_addr  = w_trap_addr;
        end else if (mret_in) begin
          w_nxt_state = ST_TRAP_RETURN;
        end
      end
      default: w_nxt_state = ST_OPERATING;
    endcase
  end

  // Output flops decode the upcoming state so strobes line up with it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_set_cause <= 1'b0;
      r_set_epc   <= 1'b0;
      r_mie_clear <= 1'b0;
      r_mie_set   <= 1'b0;
      r_flush     <= 1'b0;
      r_pc_sel    <= PC_SEL_SEQ;
      r_cause     <= '0;
      r_irq       <= 1'b0;
      r_addr      <= '0;
    end else begin
      r_set_cause <= (w_nxt_state == ST_TRAP_TAKEN);
      r_set_epc   <= (w_nxt_state == ST_TRAP_TAKEN);
      r_mie_clear <= (w_nxt_state == ST_TRAP_TAKEN);
      r_mie_set   <= (w_nxt_state == ST_TRAP_RETURN);
      r_flush     <= (w_nxt_state != ST_OPERATING);
      r_pc_sel    <= (w_nxt_state == ST_TRAP_TAKEN)  ? PC_SEL_TRAP :
                     (w_nxt_state == ST_TRAP_RETURN) ? PC_SEL_MEPC : PC_SEL_SEQ;
      r_cause     <= w_nxt_cause;
      r_irq       <= w_nxt_irq;
      r_addr      <= w_nxt_addr;
    end
  end

  assign set_cause_out = r_set_cause;
  assign set_epc_out   = r_set_epc;
  assign mie_clear_out = r_mie_clear;
  assign mie_set_out   = r_mie_set;
  assign flush_out     = r_flush;
  assign pc_sel_out    = r_pc_sel;
  assign cause_out     = r_cause;
  assign i_or_e_out    = r_irq;
  assign trap_addr_out = r_addr;

endmodule

// File: tb/tb_mtrap_ctrl.sv
// Scoreboard bench for mtrap_ctrl: a driver applies stimulus on the falling
// edge and pushes the reference model's expected outputs; a monitor pops and
// compares shortly after each rising edge. Directed scenarios add constant
// checks on top of the scoreboard.
module tb_mtrap_ctrl;

  localparam int CW = 4;
  localparam int XL = 32;

  typedef struct packed {
    logic rst, imis, ill, ebrk, ecall, lmis, smis;
    logic eirq, tirq, sirq, mie, meie, mtie, msie, mret;
    logic [XL-1:0] mtvec;
  } stim_t;

  typedef struct packed {
    logic set_cause, set_epc, mie_clr, mie_set, flush;
    logic [1:0] pc_sel;
    logic [CW-1:0] cause;
    logic ioe;
    logic [XL-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  stim_t st;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic set_cause_o, ioe_o, set_epc_o, mie_clr_o, mie_set_o, flush_o;
  logic [CW-1:0] cause_o;
  logic [1:0] pc_sel_o;
  logic [XL-1:0] addr_o;

  // Reference model state: whether the previous cycle was a trap/return
  // cycle (events ignored now), plus the held trap record.
  bit m_busy;
  logic [CW-1:0] m_cause;
  logic m_ioe;
  logic [XL-1:0] m_addr;

  always #5 clk = ~clk;

  mtrap_ctrl #(.CAUSE_W(CW), .XLEN(XL)) dut (
    .clk_in(clk), .rst_in(st.rst),
    .instr_misaligned_in(st.imis), .illegal_instr_in(st.ill),
    .ebreak_in(st.ebrk), .ecall_in(st.ecall),
    .load_misaligned_in(st.lmis), .store_misaligned_in(st.smis),
    .e_irq_in(st.eirq), .t_irq_in(st.tirq), .s_irq_in(st.sirq),
    .mie_in(st.mie), .meie_in(st.meie), .mtie_in(st.mtie), .msie_in(st.msie),
    .mret_in(st.mret), .mtvec_in(st.mtvec),
    .set_cause_out(set_cause_o), .cause_out(cause_o), .i_or_e_out(ioe_o),
    .set_epc_out(set_epc_o), .mie_clear_out(mie_clr_o), .mie_set_out(mie_set_o),
    .flush_out(flush_o), .pc_sel_out(pc_sel_o), .trap_addr_out(addr_o)
  );

  function automatic exp_t model(input stim_t s);
    exp_t e;
    bit [8:0] pend;
    int codes [9];
    int hit;
    e = '0;
    if (s.rst) begin
      m_busy = 0; m_cause = '0; m_ioe = 0; m_addr = '0;
      return e;
    end
    // priority table: first three entries are interrupts, rest exceptions
    pend  = {s.mie & s.eirq & s.meie, s.mie & s.sirq & s.msie, s.mie & s.tirq & s.mtie,
             s.imis, s.ill, s.ebrk, s.ecall, s.lmis, s.smis};
    codes = '{11, 3, 7, 0, 2, 3, 11, 4, 6};
    hit = -1;
    for (int i = 0; i < 9; i++)
      if (hit < 0 && pend[8-i]) hit = i;
    if (m_busy) begin
      m_busy = 0;
    end else if (hit >= 0) begin
      m_busy  = 1;
      m_cause = CW'(codes[hit]);
      m_ioe   = (hit < 3);
      m_addr  = {s.mtvec[XL-1:2], 2'b00};
`ifdef MTRAP_CTRL_VECTORED_EN
      if (m_ioe && s.mtvec[1:0] == 2'b01) m_addr = m_addr + 4 * codes[hit];
`endif
      e.set_cause = 1; e.set_epc = 1; e.mie_clr = 1; e.flush = 1; e.pc_sel = 2'b01;
    end else if (s.mret) begin
      m_busy = 1;
      e.mie_set = 1; e.flush = 1; e.pc_sel = 2'b10;
    end
    e.cause = m_cause; e.ioe = m_ioe; e.addr = m_addr;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a = '{set_cause_o, set_epc_o, mie_clr_o, mie_set_o, flush_o, pc_sel_o, cause_o, ioe_o, addr_o};
    return a;
  endfunction

  task automatic step(input stim_t s);
    @(negedge clk);
    st = s;
    q.push_back(model(s));
  endtask

  task automatic idle();
    stim_t s;
    s = '0;
    step(s);
  endtask

  task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: one expected record per clock.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = actual();
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL scoreboard @%0t: got %h expected %h", $time, a, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    st = '0;
    st.rst = 1'b1;
    #1;
    chk("reset_strobes", {27'd0, set_cause_o, set_epc_o, mie_clr_o, mie_set_o, flush_o}, 0);
    chk("reset_pcsel", {30'd0, pc_sel_o}, 0);
    chk("reset_addr", addr_o, 0);
    chk("reset_cause", {27'd0, ioe_o, cause_o}, 0);
    s = '0; s.rst = 1; step(s); step(s);
    idle(); idle();

    // illegal instruction, direct base 0x100
    s = '0; s.ill = 1; s.mtvec = 32'h100; step(s);
    @(posedge clk); #3;
    chk("ill_set_cause", {31'd0, set_cause_o}, 1);
    chk("ill_cause", {28'd0, cause_o}, 2);
    chk("ill_ioe", {31'd0, ioe_o}, 0);
    chk("ill_addr", addr_o, 32'h100);
    chk("ill_pcsel", {30'd0, pc_sel_o}, 2'b01);
    idle();
    @(posedge clk); #3;
    chk("ill_after_strobes", {27'd0, set_cause_o, set_epc_o, mie_clr_o, mie_set_o, flush_o}, 0);
    idle();

    // timer interrupt, mtvec mode 01
    s = '0; s.tirq = 1; s.mtie = 1; s.mie = 1; s.mtvec = 32'h201; step(s);
    @(posedge clk); #3;
    chk("tmr_cause", {28'd0, cause_o}, 7);
    chk("tmr_ioe", {31'd0, ioe_o}, 1);
`ifdef MTRAP_CTRL_VECTORED_EN
    chk("tmr_addr", addr_o, 32'h21C);
`else
    chk("tmr_addr", addr_o, 32'h200);
`endif
    idle();

    // external + software + ecall together
    s = '0; s.eirq = 1; s.sirq = 1; s.meie = 1; s.msie = 1; s.mie = 1; s.ecall = 1;
    s.mtvec = 32'h400; step(s);
    @(posedge clk); #3;
    chk("ext_cause", {28'd0, cause_o}, 11);
    chk("ext_ioe", {31'd0, ioe_o}, 1);
    idle();

    // masked timer interrupt: no strobes for 10 cycles
    for (int i = 0; i < 10; i++) begin
      s = '0; s.tirq = 1; s.mtie = 1; step(s);
      @(posedge clk); #3;
      chk("masked_strobes", {27'd0, set_cause_o, set_epc_o, mie_clr_o, mie_set_o, flush_o}, 0);
    end

    // trap beats mret
    s = '0; s.mret = 1; s.lmis = 1; s.mtvec = 32'h800; step(s);
    @(posedge clk); #3;
    chk("mret_trap_cause", {28'd0, cause_o}, 4);
    chk("mret_trap_set_cause", {31'd0, set_cause_o}, 1);
    chk("mret_trap_mie_set", {31'd0, mie_set_o}, 0);
    idle();
    s = '0; s.mret = 1; step(s);
    @(posedge clk); #3;
    chk("mret_mie_set", {31'd0, mie_set_o}, 1);
    chk("mret_pcsel", {30'd0, pc_sel_o}, 2'b10);
    idle();
    @(posedge clk); #3;
    chk("mret_after", {30'd0, mie_set_o, flush_o}, 0);

    // reset in the middle of TRAP_TAKEN
    s = '0; s.ill = 1; s.mtvec = 32'hABC0; step(s);
    @(posedge clk); #3;
    chk("pre_rst_flush", {31'd0, flush_o}, 1);
    st.rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {27'd0, set_cause_o, set_epc_o, mie_clr_o, mie_set_o, flush_o}, 0);
    chk("rst_mid_pcsel_cause", {25'd0, pc_sel_o, ioe_o, cause_o}, 0);
    chk("rst_mid_addr", addr_o, 0);
    s = '0; s.rst = 1; step(s);
    idle();
    s = '0; s.mret = 1; step(s);
    @(posedge clk); #3;
    chk("post_rst_operating", {31'd0, mie_set_o}, 1);
    idle();

    // randomized traffic checked by the scoreboard
    for (int i = 0; i < 600; i++) begin
      s = '0;
      s.imis = ($urandom_range(0, 11) == 0);
      s.ill  = ($urandom_range(0, 11) == 0);
      s.ebrk = ($urandom_range(0, 11) == 0);
      s.ecall= ($urandom_range(0, 11) == 0);
      s.lmis = ($urandom_range(0, 11) == 0);
      s.smis = ($urandom_range(0, 11) == 0);
      s.eirq = $urandom_range(0, 3) == 0;
      s.tirq = $urandom_range(0, 3) == 0;
      s.sirq = $urandom_range(0, 3) == 0;
      s.mie  = $urandom_range(0, 1);
      s.meie = $urandom_range(0, 1);
      s.mtie = $urandom_range(0, 1);
      s.msie = $urandom_range(0, 1);
      s.mret = $urandom_range(0, 3) == 0;
      s.mtvec = $urandom;
      if ($urandom_range(0, 1) == 1) s.mtvec[1:0] = 2'b01;
      s.rst  = ($urandom_range(0, 99) == 0);
      step(s);
    end
    idle();
    @(posedge clk); #3;
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
